// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : NUM_CH countdown timers advanced by a shared tick; expiries are
//               queued as pending bits and presented one at a time, round robin.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              req_valid,
    input  logic [CH_W-1:0]   req_ch,
    input  logic [CNT_W-1:0]  req_count,
    output logic              req_ready,
    output logic [NUM_CH-1:0] busy,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              evt_ready,
    output logic [NUM_CH-1:0] overrun
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CH_W-1:0]    r_evt_ch;
    logic [CH_W-1:0]    w_evt_ch_next;
    logic [CH_W-1:0]    r_rr_start;
    logic [CH_W-1:0]    w_rr_start_next;
    logic [CH_W-1:0]    w_search_start;
    logic [CH_W-1:0]    w_win_ch;
    logic               w_win_found;
    logic [NUM_CH-1:0]  r_busy;
    logic [NUM_CH-1:0]  r_pending;
    logic [NUM_CH-1:0]  r_overrun;
    logic [NUM_CH-1:0]  w_arm;
    logic [NUM_CH-1:0]  w_expire;
    logic [NUM_CH-1:0]  w_clear;
    logic [NUM_CH-1:0]  w_search;
    logic [CNT_W-1:0]   r_cnt [NUM_CH];
    logic [CNT_W-1:0]   w_load;
    logic               w_req_in_range;
    logic               w_handshake;

    assign w_req_in_range = ({1'b0, req_ch} < (CH_W+1)'(NUM_CH));
    assign req_ready      = w_req_in_range && !r_busy[req_ch];
    assign w_load         = (req_count == '0) ? CNT_W'(1) : req_count;
    assign w_handshake    = (r_state == ST_PRESENT) && evt_ready;

    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign evt_valid = (r_state == ST_PRESENT);
    assign evt_ch    = r_evt_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_arm[i]    = req_valid && req_ready && (req_ch == CH_W'(i));
        assign w_expire[i] = tick && r_busy[i] && (r_cnt[i] == CNT_W'(1));
        assign w_clear[i]  = w_handshake && (r_evt_ch == CH_W'(i));
    end

    // An arm only targets an idle channel, so it never competes with a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_arm[i]) begin
                    r_cnt[i]  <= w_load;
                    r_busy[i] <= 1'b1;
                end else if (tick && r_busy[i]) begin
                    if (w_expire[i]) begin
                        r_cnt[i]  <= '0;
                        r_busy[i] <= 1'b0;
                    end else begin
                        r_cnt[i]  <= r_cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    // A fresh expiry of the channel being acknowledged re-arms its pending bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_expire;
            r_overrun <= r_overrun | (w_expire & r_pending & ~w_clear);
        end
    end

    assign w_search       = r_pending & ~w_clear;
    assign w_search_start = !w_handshake ? r_rr_start :
                            (r_evt_ch == CH_W'(NUM_CH - 1)) ? '0 : r_evt_ch + 1'b1;

    always_comb begin
        logic [CH_W-1:0] idx;
        w_win_found = 1'b0;
        w_win_ch    = '0;
        idx         = w_search_start;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_win_found && w_search[idx]) begin
                w_win_found = 1'b1;
                w_win_ch    = idx;
            end
            idx = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_evt_ch_next   = r_evt_ch;
        w_rr_start_next = r_rr_start;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_state_next  = ST_PRESENT;
                    w_evt_ch_next = w_win_ch;
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    w_rr_start_next = w_search_start;
                    if (w_win_found) begin
                        w_evt_ch_next = w_win_ch;
                    end else begin
                        w_state_next  = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_evt_ch   <= '0;
            r_rr_start <= '0;
        end else begin
            r_state    <= w_state_next;
            r_evt_ch   <= w_evt_ch_next;
            r_rr_start <= w_rr_start_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Randomised and directed bench for tick_scheduler with a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic              req_valid;
    logic [CH_W-1:0]   req_ch;
    logic [CNT_W-1:0]  req_count;
    logic              req_ready;
    logic [NUM_CH-1:0] busy;
    logic              evt_valid;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_ready;
    logic [NUM_CH-1:0] overrun;

    tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .req_valid (req_valid),
        .req_ch    (req_ch),
        .req_count (req_count),
        .req_ready (req_ready),
        .busy      (busy),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid_seen;
    int hs_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remaining ticks per timer, set of pending channels.
    bit [NUM_CH-1:0] m_busy;
    bit [NUM_CH-1:0] m_pend;
    bit [NUM_CH-1:0] m_ovr;
    int              m_rem [NUM_CH];
    bit              m_valid;
    int              m_ch;
    int              m_last;

    function automatic int rr_pick(input bit [NUM_CH-1:0] v, input int start);
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[(start + k) % NUM_CH]) return (start + k) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = '0; m_pend = '0; m_ovr = '0;
        m_valid = 1'b0; m_ch = 0; m_last = NUM_CH - 1;
        for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
    endtask

    task automatic model_step();
        bit              hs;
        bit [NUM_CH-1:0] old_pend;
        bit [NUM_CH-1:0] rest;
        int              arm_ch;
        int              w;
        if (reset) begin
            model_reset();
            return;
        end
        hs       = m_valid && evt_ready;
        old_pend = m_pend;
        arm_ch   = (req_valid && !m_busy[req_ch]) ? int'(req_ch) : -1;
        if (hs) m_pend[m_ch] = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (tick && m_busy[c]) begin
                if (m_rem[c] == 1) begin
                    m_busy[c] = 1'b0;
                    m_rem[c]  = 0;
                    if (m_pend[c]) m_ovr[c] = 1'b1;
                    m_pend[c] = 1'b1;
                end else begin
                    m_rem[c] = m_rem[c] - 1;
                end
            end
        end
        if (arm_ch >= 0) begin
            m_busy[arm_ch] = 1'b1;
            m_rem[arm_ch]  = (req_count == 0) ? 1 : int'(req_count);
        end
        if (!m_valid) begin
            w = rr_pick(old_pend, (m_last + 1) % NUM_CH);
            if (w >= 0) begin
                m_valid = 1'b1;
                m_ch    = w;
            end
        end else if (hs) begin
            m_last = m_ch;
            rest   = old_pend;
            rest[m_ch] = 1'b0;
            w = rr_pick(rest, (m_ch + 1) % NUM_CH);
            if (w >= 0) m_ch = w;
            else        m_valid = 1'b0;
        end
    endtask

    task automatic cycle();
        #1;
        check_eq("req_ready", req_ready, !m_busy[req_ch]);
        if (evt_valid) n_valid_seen++;
        if (evt_valid && evt_ready) hs_log.push_back(int'(evt_ch));
        @(posedge clk);
        model_step();
        #1;
        check_eq("busy", busy, m_busy);
        check_eq("evt_valid", evt_valid, m_valid);
        if (m_valid) check_eq("evt_ch", evt_ch, m_ch);
        check_eq("overrun", overrun, m_ovr);
    endtask

    task automatic arm(input int ch, input int cnt, input bit with_tick);
        req_valid = 1'b1; req_ch = CH_W'(ch); req_count = CNT_W'(cnt); tick = with_tick;
        cycle();
        req_valid = 1'b0; tick = 1'b0;
    endtask

    task automatic run(input int n, input int period);
        for (int k = 0; k < n; k++) begin
            tick = (period > 0) && (k % period == period - 1);
            cycle();
        end
        tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; req_valid = 1'b0; req_ch = '0;
        req_count = '0; evt_ready = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_evt_valid", evt_valid, 0);
        check_eq("rst_evt_ch", evt_ch, 0);
        check_eq("rst_overrun", overrun, 0);

        // Single timer latency
        evt_ready = 1'b1;
        arm(1, 3, 1'b0);
        n_valid_seen = 0;
        run(25, 5);
        check_eq("single_evt_count", n_valid_seen, 1);

        // Simultaneous expiries, stalled consumer, round-robin drain
        do_reset();
        evt_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) arm(c, 2, 1'b0);
        run(2, 1);
        run(10, 0);
        check_eq("stall_evt_ch", evt_ch, 0);
        hs_log.delete();
        evt_ready = 1'b1;
        run(6, 0);
        check_eq("drain_len", hs_log.size(), 4);
        for (int c = 0; c < NUM_CH && c < hs_log.size(); c++)
            check_eq("drain_order", hs_log[c], c);

        // Zero count and arm while busy
        do_reset();
        arm(2, 0, 1'b0);
        arm(2, 5, 1'b0);
        tick = 1'b1; cycle(); tick = 1'b0;
        check_eq("zero_cnt_expired", busy[2], 0);
        run(4, 0);

        // Overrun on second expiry while pending
        do_reset();
        evt_ready = 1'b0;
        arm(3, 1, 1'b0);
        run(1, 1);
        arm(3, 1, 1'b0);
        run(1, 1);
        check_eq("overrun3", overrun[3], 1);
        hs_log.delete();
        evt_ready = 1'b1;
        run(5, 0);
        check_eq("overrun_single_evt", hs_log.size(), 1);

        // Reset mid-count discards the timer
        do_reset();
        arm(1, 5, 1'b0);
        run(2, 1);
        do_reset();
        check_eq("midrst_busy", busy, 0);
        n_valid_seen = 0;
        run(10, 1);
        check_eq("midrst_no_evt", n_valid_seen, 0);

        // Tick coincident with arm is not counted
        do_reset();
        arm(0, 2, 1'b1);
        run(1, 1);
        check_eq("arm_tick_first", busy[0], 1);
        run(1, 1);
        check_eq("arm_tick_second", busy[0], 0);
        run(3, 0);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            reset     = ($urandom_range(0, 299) == 0);
            tick      = ($urandom_range(0, 2) == 0);
            req_valid = $urandom_range(0, 1);
            req_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            req_count = CNT_W'($urandom_range(0, 4));
            evt_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent countdown channels; legal range 2..8.
REQ-002 Parameter CNT_W, default 8: width of each channel's countdown counter.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 tick  input  1  one-cycle time-base pulse from clock_div; each high cycle is one timer tick.
REQ-006 req_valid  input  1  arm request present.
REQ-007 req_ch  input  clog2(NUM_CH)  channel to arm.
REQ-008 req_count  input  CNT_W  tick count before expiry.
REQ-009 req_ready  output  1  combinational; high when busy[req_ch]==0.
REQ-010 busy  output  NUM_CH  per-channel "armed and counting" flags.
REQ-011 evt_valid  output  1  registered; an expiry event is presented.
REQ-012 evt_ch  output  clog2(NUM_CH)  registered; channel of the presented event.
REQ-013 evt_ready  input  1  consumer accepts the event.
REQ-014 overrun  output  NUM_CH  sticky; a channel expired while its previous event was still pending.

Function
REQ-015 Arm: req_valid && req_ready loads cnt[req_ch] with max(req_count,1) and sets busy[req_ch] on the next edge.
REQ-016 req_valid with req_ready low shall be ignored; no state change.
REQ-017 Count: on a tick cycle, each busy channel with cnt>1 decrements by 1.
REQ-018 Expiry: on a tick cycle, a busy channel with cnt==1 clears busy, sets cnt=0, and sets pending[ch]; expiry occurs exactly on the Nth tick after arming (N=max(req_count,1)).
REQ-019 A tick in the same cycle as an arm of a channel shall not be counted for that channel's new load.
REQ-020 Ticks on non-busy channels shall have no effect; counters shall never wrap below 0.
REQ-021 Multiple channels may expire on the same tick; each sets its own pending bit.
REQ-022 If a channel expires while pending[ch] is already 1, overrun[ch] shall set; pending stays 1 (events merge).
REQ-023 Event FSM states: IDLE (evt_valid=0) and PRESENT (evt_valid=1).
REQ-024 IDLE -> PRESENT when any pending bit is 1: evt_ch latched to the round-robin winner on that edge, evt_valid rises the cycle after pending is visible.
REQ-025 Round robin: search starts at (last granted channel + 1) mod NUM_CH; after reset search starts at channel 0.
REQ-026 In PRESENT, evt_ch and evt_valid shall be held stable until evt_valid && evt_ready.
REQ-027 On handshake: pending[evt_ch] clears, last-granted pointer updates to evt_ch; next state PRESENT with next winner if other pending bits remain (back-to-back, no bubble), else IDLE.
REQ-028 An expiry of evt_ch in the handshake cycle shall re-set pending[evt_ch] (set wins over clear) without overrun.
REQ-029 A channel may be re-armed while its pending bit is set; pending and counting are independent.
REQ-030 evt_ready while evt_valid is low shall be ignored.

Reset
REQ-031 On reset: busy=0, all cnt=0, pending=0, overrun=0, evt_valid=0, evt_ch=0, FSM=IDLE, round-robin pointer so channel 0 is searched first.
REQ-032 Reset asserted mid-count or mid-handshake shall discard all armed timers and pending events; no event is issued after reset deasserts.

Verification
REQ-033 Arm ch1 count 3, tick every 5 cycles, evt_ready=1 -> busy[1] falls on 3rd tick edge, evt_valid=1 with evt_ch=1 one cycle later for exactly one cycle.
REQ-034 Arm ch0..3 count 2 each, evt_ready=0 for 10 cycles after expiry, then 1 -> events delivered 0,1,2,3 back-to-back, evt_ch stable while stalled.
REQ-035 Arm ch2 count 0 -> expires on first tick (treated as 1); arm ch2 again while busy -> req_ready=0, request dropped.
REQ-036 Arm ch3 count 1, hold evt_ready=0, re-arm ch3 count 1, next tick -> overrun[3]=1, single event for ch3 after evt_ready=1.
REQ-037 Arm ch1 count 5, after 2 ticks assert reset 1 cycle -> busy=0, evt_valid=0, no event for 10 further ticks.
REQ-038 Arm in the same cycle as tick with count 2 -> expiry on 2nd subsequent tick, not 1st.
